// File: rtl/unary_add_1_4_6.sv
// Serial unary (thermometer) adder: accumulates A+B in read mode, emits the total as a run of ones in write mode.
// Optional macro UNARY_ADD_SAT_EN: saturate at 63 with a sticky C; default build wraps mod 64 with a one-cycle C pulse.
module unary_add_1_4_6 (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic en,
    input  logic read_or_write,
    output logic dout,
    output logic C
);

    logic [5:0] r_cnt;
    logic       r_dout;
    logic       r_c;

    logic [6:0] w_sum;
    logic       w_ovf;
    logic       w_nonzero;

    // Seven-bit sum so the carry out of the 6-bit count is the overflow condition.
    assign w_sum     = {1'b0, r_cnt} + {6'b0, A} + {6'b0, B};
    assign w_ovf     = w_sum[6];
    assign w_nonzero = (r_cnt != 6'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= 6'd0;
            r_dout <= 1'b0;
            r_c    <= 1'b0;
        end else if (!en) begin
            r_dout <= 1'b0;
        end else if (!read_or_write) begin
            r_dout <= 1'b0;
`ifdef UNARY_ADD_SAT_EN
            if (w_ovf) begin
                r_cnt <= 6'd63;
                r_c   <= 1'b1;
            end else begin
                r_cnt <= w_sum[5:0];
            end
`else
            r_cnt <= w_sum[5:0];
            r_c   <= w_ovf;
`endif
        end else begin
            // A and B are deliberately unused while emitting.
            if (w_nonzero) begin
                r_dout <= 1'b1;
                r_cnt  <= r_cnt - 6'd1;
            end else begin
                r_dout <= 1'b0;
            end
`ifndef UNARY_ADD_SAT_EN
            r_c <= 1'b0;
`endif
        end
    end

    assign dout = r_dout;
    assign C    = r_c;

endmodule

// File: tb/tb_unary_add_1_4_6.sv
// Directed bench for unary_add_1_4_6: a per-cycle vector table plus hand sequences for multi-cycle cases.
// Expected values track the UNARY_ADD_SAT_EN setting of the build.
module tb_unary_add_1_4_6;

    logic clk;
    logic rst_n;
    logic A;
    logic B;
    logic en;
    logic read_or_write;
    logic dout;
    logic C;

    int n_vec;
    int n_err;

    unary_add_1_4_6 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (read_or_write),
        .dout          (dout),
        .C             (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst_n;
        logic en;
        logic rw;
        logic a;
        logic b;
        logic exp_dout;
        logic exp_c;
    } vec_t;

`ifdef UNARY_ADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, then sample just after the rising edge.
    task automatic step(input logic r, input logic e, input logic rw, input logic a, input logic b);
        @(negedge clk);
        rst_n = r;
        en = e;
        read_or_write = rw;
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    // Write-mode cycles until dout drops; returns length of the run of ones.
    task automatic emit_run(input int limit, input logic exp_c, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            if (dout !== 1'b1) break;
            n++;
            if (i == limit - 1) chk("emit_bound", 1'b1, 1'b0);
        end
        chk("emit_c", C, exp_c);
    endtask

    vec_t vt[14];
    int   n_ones;
    int   exp_ones;
    int   n_cpulse;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        en = 1'b0;
        read_or_write = 1'b0;
        A = 1'b0;
        B = 1'b0;

        //          rst  en   rw   a    b    dout c
        vt[0]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0};
        vt[1]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
        vt[2]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0};
        vt[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
        vt[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
        vt[5]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0};
        vt[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
        vt[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
        vt[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
        vt[9]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0};
        vt[10] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0};
        vt[11] = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0};
        vt[12] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0};
        vt[13] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0};

        for (int i = 0; i < 14; i++) begin
            step(vt[i].rst_n, vt[i].en, vt[i].rw, vt[i].a, vt[i].b);
            chk($sformatf("vec%0d_dout", i), dout, vt[i].exp_dout);
            chk($sformatf("vec%0d_c", i), C, vt[i].exp_c);
        end

        // A=B=1 for 7 cycles gives 14 ones.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("acc14_c", C, 1'b0);
        emit_run(80, 1'b0, n_ones);
        chk("run14", n_ones == 14, 1'b1);

        // 3 cycles of A only, 2 of B only: 5 ones.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        emit_run(80, 1'b0, n_ones);
        chk("run5", n_ones == 5, 1'b1);

        // Load 4, hold with en=0 in write mode, then emit 4.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            chk($sformatf("hold_dout%0d", i), dout, 1'b0);
        end
        emit_run(80, 1'b0, n_ones);
        chk("run4_after_hold", n_ones == 4, 1'b1);

        // 33 cycles of A=B=1: crosses 63 on cycle 32.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cpulse = 0;
        for (int i = 1; i <= 33; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            if (C === 1'b1) n_cpulse++;
            chk($sformatf("ovf_c%0d", i), C, SAT ? (i >= 32) : (i == 32));
        end
        chk("ovf_pulses", n_cpulse == (SAT ? 2 : 1), 1'b1);
        exp_ones = SAT ? 63 : 2;
        emit_run(80, SAT, n_ones);
        chk("ovf_run", n_ones == exp_ones, 1'b1);

        // Reset midway through emitting 10 ones.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_c_clear", C, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("pre_rst_dout%0d", i), dout, 1'b1);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mid_rst_dout", dout, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("post_rst_dout%0d", i), dout, 1'b0);
        end

        // Write with cnt=0 must not underflow: a single load emits one.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        emit_run(80, 1'b0, n_ones);
        chk("no_underflow", n_ones == 1, 1'b1);

        // Mode switch mid-emission keeps the remainder: 6 loaded, 2 out, +1, 5 out.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("resume_read_dout", dout, 1'b0);
        emit_run(80, 1'b0, n_ones);
        chk("resume_run", n_ones == 5, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/unary_add_1_4_6.md
UNARY_ADD_1_4_6 -- requirements
Module: unary_add_1_4_6

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL: rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL: A  input  1  serial unary (thermometer) operand bit; one bit sampled per enabled read cycle.
REQ-004 SHALL: B  input  1  serial unary operand bit; sampled alongside A.
REQ-005 SHALL: en  input  1  cycle enable; when low, the counter and C hold and dout is 0.
REQ-006 SHALL: read_or_write  input  1  mode select: 0 = read/accumulate, 1 = write/emit.
REQ-007 SHALL: dout  output  1  registered serial unary result stream.
REQ-008 SHALL: C  output  1  registered overflow flag.

Function
REQ-009 SHALL: hold an internal 6-bit unsigned count register cnt (range 0..63).
REQ-010 SHALL: in read mode with en=1, at each rising edge, set cnt <= cnt + A + B (adds 0, 1 or 2 per cycle) and drive dout <= 0.
REQ-011 SHALL: in write mode with en=1, at each rising edge, if cnt > 0 then set dout <= 1 and cnt <= cnt - 1; otherwise set dout <= 0 and leave cnt at 0.
REQ-012 SHALL: in write mode, ignore A and B.
REQ-013 SHALL: produce exactly N consecutive dout=1 cycles after the first write-mode edge when cnt=N at mode entry, followed by dout=0. Latency is 1 cycle, because dout is registered.
REQ-014 SHALL: with en=0, hold cnt and C unchanged and drive dout <= 0.
REQ-015 SHALL: on a read<->write mode change, retain cnt. Switching back to read mid-emission resumes accumulation from the remaining cnt.
REQ-016 SHALL: treat an overflow as any read-mode cycle where cnt + A + B > 63. The handling is defined under Configuration.
REQ-017 SHALL: have no combinational path from inputs to outputs.

Reset
REQ-018 SHALL: when rst_n=0 at a rising edge, set cnt=0, dout=0 and C=0, with priority over en and mode.
REQ-019 SHALL: when reset is asserted mid-accumulation or mid-emission, discard the count; the first cycle after release behaves as if starting from cnt=0.

Configuration
REQ-020 SHALL: support the macro UNARY_ADD_SAT_EN.
REQ-021 SHALL: with UNARY_ADD_SAT_EN defined, on overflow set cnt to 63 (saturate) and set C <= 1. C is sticky until reset.
REQ-022 SHALL: with UNARY_ADD_SAT_EN undefined, on overflow set cnt <= (cnt + A + B) mod 64 (wrap) and set C = 1 for exactly that one cycle. Otherwise C = 0.

Verification
REQ-023 SHALL: cover this case: reset, then en=1 with read, A=B=1 for 7 cycles, then write -> dout=1 for exactly 14 consecutive cycles, then 0; C stays 0.
REQ-024 SHALL: cover this case: read with A=1,B=0 for 3 cycles and A=0,B=1 for 2 cycles, then write -> dout high exactly 5 cycles.
REQ-025 SHALL: cover this case: cnt=4, en=0 for 5 cycles during write -> dout=0 throughout; after en=1, dout high 4 cycles.
REQ-026 SHALL: cover this case: A=B=1 for 33 cycles -> with UNARY_ADD_SAT_EN, cnt=63, C=1 sticky and write emits 63 ones; without the macro, C pulses once at the 64 crossing, cnt=2, and write emits 2 ones.
REQ-027 SHALL: cover this case: rst_n=0 for one edge midway through emitting 10 ones -> dout=0 and cnt=0 on the next edge, with no further ones.
REQ-028 SHALL: cover this case: write with cnt=0 -> dout stays 0 and cnt does not underflow.
